// File: rtl/shape_processor_pkg.sv
// shape_processor_pkg: CTRL SFR layout, response codes and writer FSM states
package shape_processor_pkg;

    localparam int CTRL_SHAPE_W = 3;
    localparam int CTRL_OP_W    = 3;
    localparam int CTRL_RSVD_W  = 32 - CTRL_SHAPE_W - CTRL_OP_W;

    typedef struct packed {
        logic [CTRL_RSVD_W-1:0]  reserved;
        logic [CTRL_SHAPE_W-1:0] shape;
        logic [CTRL_OP_W-1:0]    operation;
    } ctrl_sfr_reg;

    typedef enum logic [1:0] {
        RSP_OK        = 2'b00,
        RSP_REJECTED  = 2'b01,
        RSP_READ_DONE = 2'b10,
        RSP_CORRUPT   = 2'b11
    } rsp_status_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE_RD,
        ST_PRE_WAIT,
        ST_WR,
        ST_POST_RD,
        ST_POST_WAIT,
        ST_RESP
    } writer_state_e;

    function automatic ctrl_sfr_reg pack_ctrl(input logic [CTRL_SHAPE_W-1:0] shape,
                                              input logic [CTRL_OP_W-1:0] op);
        pack_ctrl = '{reserved: '0, shape: shape, operation: op};
    endfunction

endpackage

// File: rtl/shape_processor_sfr_read_timer.sv
// shape_processor_sfr_read_timer: pulses capture READ_LATENCY cycles after start
module shape_processor_sfr_read_timer #(
    parameter int READ_LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic capture
);

    if (READ_LATENCY < 1 || READ_LATENCY > 7) begin : g_bad_latency
        $error("READ_LATENCY must be in 1..7");
    end

    logic [2:0] cnt;
    logic       armed;

    // Count down from READ_LATENCY-1 after the read strobe; capture fires at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            armed <= 1'b0;
            cnt   <= '0;
        end else if (start) begin
            armed <= 1'b1;
            cnt   <= 3'(READ_LATENCY - 1);
        end else if (armed) begin
            if (cnt == 3'd0)
                armed <= 1'b0;
            else
                cnt <= cnt - 3'd1;
        end
    end

    assign capture = armed && (cnt == 3'd0);

endmodule

// File: rtl/shape_processor_ctrl_writer.sv
// shape_processor_ctrl_writer: turns config requests into verified CTRL SFR transactions
module shape_processor_ctrl_writer
    import shape_processor_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int SHAPE_W      = CTRL_SHAPE_W,
    parameter int OP_W         = CTRL_OP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [SHAPE_W-1:0] req_shape,
    input  logic [OP_W-1:0]    req_operation,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [1:0]         rsp_status,
    output logic [SHAPE_W-1:0] rsp_shape,
    output logic [OP_W-1:0]    rsp_operation,
    output logic               write,
    output logic [31:0]        write_data,
    output logic               read,
    input  logic [31:0]        read_data
);

    if (SHAPE_W != CTRL_SHAPE_W || OP_W != CTRL_OP_W) begin : g_bad_widths
        $error("SHAPE_W/OP_W must match the CTRL register layout");
    end

    writer_state_e state, next;
    ctrl_sfr_reg   req_img, pre_val, post_val;
    logic          req_wr;
    logic          capture;
    rsp_status_e   status;

    shape_processor_sfr_read_timer #(.READ_LATENCY(READ_LATENCY)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (read),
        .capture (capture)
    );

    // State register; reset abandons any in-flight transaction
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next;
    end

    // Latch the request and the two readback samples
    always_ff @(posedge clk) begin
        if (rst) begin
            req_wr   <= 1'b0;
            req_img  <= '0;
            pre_val  <= '0;
            post_val <= '0;
        end else begin
            if (req_valid && req_ready) begin
                req_wr  <= req_write;
                req_img <= pack_ctrl(req_shape, req_operation);
            end
            if (state == ST_PRE_WAIT && capture)
                pre_val <= read_data;
            if (state == ST_POST_WAIT && capture)
                post_val <= read_data;
        end
    end

    // Next-state: pre-read, write, post-read for writes; post-read only for reads
    always_comb begin
        next = state;
        case (state)
            ST_IDLE:      if (req_valid) next = req_write ? ST_PRE_RD : ST_POST_RD;
            ST_PRE_RD:    next = ST_PRE_WAIT;
            ST_PRE_WAIT:  if (capture) next = ST_WR;
            ST_WR:        next = ST_POST_RD;
            ST_POST_RD:   next = ST_POST_WAIT;
            ST_POST_WAIT: if (capture) next = ST_RESP;
            ST_RESP:      if (rsp_ready) next = ST_IDLE;
            default:      next = ST_IDLE;
        endcase
    end

    // Outcome: matching readback wins; otherwise unchanged CTRL means the slave dropped the write
    always_comb begin
        status = !req_wr ? RSP_READ_DONE :
                 ({post_val.shape, post_val.operation} == {req_img.shape, req_img.operation}) ? RSP_OK :
                 (post_val == pre_val) ? RSP_REJECTED : RSP_CORRUPT;
    end

    // Bus strobes and response fields are decoded from state and zero elsewhere
    always_comb begin
        req_ready     = (state == ST_IDLE) && !rst;
        write         = (state == ST_WR);
        write_data    = write ? req_img : 32'h0;
        read          = (state == ST_PRE_RD) || (state == ST_POST_RD);
        rsp_valid     = (state == ST_RESP);
        rsp_status    = rsp_valid ? status : 2'b00;
        rsp_shape     = rsp_valid ? post_val.shape : '0;
        rsp_operation = rsp_valid ? post_val.operation : '0;
    end

endmodule
